alu_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing the single 16-bit ALU among NUM_REQ requesters (e.g. decode/execute, address-gen, debug port).
- Each requester issues {A, B, op} over a valid/ready request channel and receives the 16-bit result over a valid/ready response channel.
- Sits between the requesters and the ALU, drives the ALU operand/op inputs from registers, and captures its combinational output one cycle later.

---
 rtl/alu_arbiter.sv | 100 ++++++++++
 tb/tb_alu_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sequencing NUM_REQ requesters onto one shared 16-bit ALU
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [16*NUM_REQ-1:0]  req_a_i,
    input  logic [16*NUM_REQ-1:0]  req_b_i,
    input  logic [3*NUM_REQ-1:0]   req_op_i,
    output logic [NUM_REQ-1:0]     resp_valid_o,
    input  logic [NUM_REQ-1:0]     resp_ready_i,
    output logic [15:0]            resp_data_o,
    output logic                   resp_err_o,
    output logic [15:0]            alu_a_o,
    output logic [15:0]            alu_b_o,
    output logic [2:0]             alu_op_o,
    input  logic [15:0]            alu_out_i,
    output logic [IDW-1:0]         grant_id_o,
    output logic                   busy_o
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] last_q, grant_q, win_id;
    logic           win_found;
    logic [15:0]    alu_a_q, alu_b_q, resp_data_q;
    logic [2:0]     alu_op_q;
    logic           resp_err_q;

    // Winner search from last+1 upward with wrap; descending loop lets the nearest valid overwrite
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid_i[(int'(last_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_id    = IDW'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: IDLE waits for a winner, EXEC lasts one cycle, RESP waits for the owner's ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = win_found ? EXEC : IDLE;
            EXEC:    state_d = RESP;
            RESP:    state_d = resp_ready_i[grant_q] ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; ready is held low while reset is asserted even though the FSM sits in IDLE
    always_comb begin
        req_ready_o  = (rst_n_i && state_q == IDLE && win_found) ? NUM_REQ'(1) << win_id : '0;
        resp_valid_o = (state_q == RESP) ? NUM_REQ'(1) << grant_q : '0;
        busy_o       = state_q != IDLE;
    end

    // Operand capture on the request handshake, result capture at the end of EXEC
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            grant_q     <= '0;
            last_q      <= IDW'(NUM_REQ - 1);
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && win_found) begin
                alu_a_q  <= req_a_i[16*int'(win_id) +: 16];
                alu_b_q  <= req_b_i[16*int'(win_id) +: 16];
                alu_op_q <= req_op_i[3*int'(win_id) +: 3];
                grant_q  <= win_id;
                last_q   <= win_id;
            end
            if (state_q == EXEC) begin
                resp_data_q <= (alu_op_q == 3'd7) ? '0 : alu_out_i;
                resp_err_q  <= alu_op_q == 3'd7;
            end
        end
    end

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign grant_id_o  = grant_q;
    assign resp_data_o = resp_data_q;
    assign resp_err_o  = resp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table-driven bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [63:0] req_a, req_b;
    logic [11:0] req_op;
    logic [15:0] resp_data, alu_a, alu_b, alu_out;
    logic        resp_err, busy;
    logic [2:0]  alu_op;
    logic [1:0]  grant_id;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          r;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    alu_arbiter #(.NUM_REQ(4), .IDW(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .resp_err_o(resp_err),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_out_i(alu_out),
        .grant_id_o(grant_id), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; op 7 yields garbage so the arbiter's forced zero is observable
    always_comb begin
        case (alu_op)
            3'd0:    alu_out = alu_a + alu_b;
            3'd1:    alu_out = alu_a - alu_b;
            3'd2:    alu_out = alu_a & alu_b;
            3'd3:    alu_out = alu_a | alu_b;
            3'd4:    alu_out = alu_a ^ alu_b;
            3'd5:    alu_out = alu_a << alu_b;
            3'd6:    alu_out = alu_a >> alu_b;
            default: alu_out = 16'hDEAD;
        endcase
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        req_a[16*r +: 16] = a;
        req_b[16*r +: 16] = b;
        req_op[3*r +: 3]  = op;
    endtask

    task automatic do_txn(input vec_t v);
        set_req(v.r, v.a, v.b, v.op);
        req_valid  = 4'(1 << v.r);
        resp_ready = 4'b0000;
        #1;
        chk("txn_req_ready", req_ready, 1 << v.r);
        tick();
        chk("txn_alu_a", alu_a, v.a);
        chk("txn_alu_b", alu_b, v.b);
        chk("txn_alu_op", alu_op, v.op);
        chk("txn_grant", grant_id, v.r);
        chk("txn_exec_ready", req_ready, 0);
        chk("txn_exec_busy", busy, 1);
        req_valid  = 4'b0000;
        resp_ready = 4'(1 << v.r);
        tick();
        chk("txn_resp_valid", resp_valid, 1 << v.r);
        chk("txn_resp_data", resp_data, v.exp);
        chk("txn_resp_err", resp_err, v.err);
        tick();
        chk("txn_done_valid", resp_valid, 0);
        chk("txn_done_busy", busy, 0);
        resp_ready = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2, 16'h7FFF, 16'h0001, 3'd0, 16'h8000, 1'b0};
        vecs[1] = '{1, 16'h0005, 16'h0009, 3'd1, 16'hFFFC, 1'b0};
        vecs[2] = '{0, 16'hF0F0, 16'h0FF0, 3'd2, 16'h00F0, 1'b0};
        vecs[3] = '{3, 16'h1200, 16'h0034, 3'd3, 16'h1234, 1'b0};
        vecs[4] = '{2, 16'hFFFF, 16'h00FF, 3'd4, 16'hFF00, 1'b0};
        vecs[5] = '{1, 16'h0001, 16'h000F, 3'd5, 16'h8000, 1'b0};
        vecs[6] = '{0, 16'h0001, 16'h0010, 3'd5, 16'h0000, 1'b0};
        vecs[7] = '{3, 16'h1234, 16'h0001, 3'd7, 16'h0000, 1'b1};
        vecs[8] = '{3, 16'h8000, 16'h0004, 3'd6, 16'h0800, 1'b0};
        vecs[9] = '{0, 16'h8000, 16'h0001, 3'd1, 16'h7FFF, 1'b0};

        // reset with toggling inputs
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid  = 4'($urandom);
            resp_ready = 4'($urandom);
            req_a      = {$urandom, $urandom};
            req_b      = {$urandom, $urandom};
            req_op     = 12'($urandom);
            tick();
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_alu", {alu_a, alu_b}, 0);
            chk("rst_alu_op", alu_op, 0);
            chk("rst_resp", {resp_err, resp_data}, 0);
            chk("rst_grant_busy", {grant_id, busy}, 0);
        end
        req_valid  = 4'b0000;
        resp_ready = 4'b0000;
        req_a = '0; req_b = '0; req_op = '0;
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_req_ready", req_ready, 0);
        chk("idle_resp_valid", resp_valid, 0);

        // table-driven single transactions
        for (int i = 0; i < 10; i++) do_txn(vecs[i]);

        // backpressure on requester 1 while requester 3 waits
        set_req(1, 16'h0005, 16'h0009, 3'd1);
        set_req(3, 16'h0100, 16'h0023, 3'd0);
        req_valid = 4'b0010;
        #1;
        chk("bp_req_ready", req_ready, 4'b0010);
        tick();
        req_valid  = 4'b1000;
        resp_ready = 4'b1101;
        #1;
        chk("bp_exec_ready", req_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", resp_valid, 4'b0010);
            chk("bp_hold_data", resp_data, 16'hFFFC);
            chk("bp_hold_ready", req_ready, 0);
            tick();
        end
        resp_ready = 4'b0010;
        #1;
        chk("bp_release_valid", resp_valid, 4'b0010);
        tick();
        chk("bp_next_ready", req_ready, 4'b1000);
        tick();
        chk("bp_next_grant", grant_id, 3);
        req_valid  = 4'b0000;
        resp_ready = 4'b1000;
        tick();
        chk("bp_next_data", resp_data, 16'h0123);
        tick();
        resp_ready = 4'b0000;

        // reset during EXEC drops the transaction and restores requester 0 priority
        set_req(3, 16'h1111, 16'h2222, 3'd0);
        set_req(0, 16'h0003, 16'h0004, 3'd0);
        req_valid = 4'b1000;
        #1;
        chk("mr_req_ready", req_ready, 4'b1000);
        tick();
        chk("mr_exec_grant", grant_id, 3);
        rst_n = 1'b0;
        #1;
        chk("mr_rst_valid", resp_valid, 0);
        chk("mr_rst_busy", busy, 0);
        chk("mr_rst_alu_a", alu_a, 0);
        req_valid = 4'b1001;
        tick();
        chk("mr_rst_ready", req_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("mr_first_ready", req_ready, 4'b0001);
        tick();
        chk("mr_first_grant", grant_id, 0);
        req_valid  = 4'b0000;
        resp_ready = 4'b0001;
        tick();
        chk("mr_resp_valid", resp_valid, 4'b0001);
        chk("mr_resp_data", resp_data, 16'h0007);
        tick();
        resp_ready = 4'b0000;

        // round-robin with everyone valid after a fresh reset
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) set_req(i, 16'(i + 1), 16'h0010, 3'd0);
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            chk("rr_ready", req_ready, 1 << (g % 4));
            tick();
            chk("rr_grant", grant_id, g % 4);
            chk("rr_exec_ready", req_ready, 0);
            tick();
            chk("rr_resp_valid", resp_valid, 1 << (g % 4));
            chk("rr_resp_data", resp_data, 16'h0010 + 16'(g % 4 + 1));
            tick();
        end
        req_valid  = 4'b0000;
        resp_ready = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
